cursor_sprite_renderer: RTL and testbench
=========================================

Name: cursor_sprite_renderer

Overview:
Parametrised cursor renderer that paints a SIZE x SIZE square cursor into the shared framebuffer through a valid/ready pixel-write port, instead of owning a private frame array. Tracks the drawn cursor's position and colour. On a move it erases the old footprint with COLOR_NONE, then draws the new one. On a colour-only change it redraws in place. Clips pixels that fall outside the screen. Sits between the cursor-position/colour logic and the framebuffer write arbiter.

Parameters:
WIDTH, 640, screen width in pixels
HEIGHT, 480, screen height in pixels
SIZE, 2, cursor side length in pixels; legal range 1..15

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
cursor_x  input  $clog2(WIDTH)  requested cursor top-left x
cursor_y  input  $clog2(HEIGHT)  requested cursor top-left y
current_color  input  COLOR_WIDTH  requested cursor colour (common.sv encoding)
enable  input  1  1 = cursor visible; 0 = cursor hidden/erased
wr_valid  output  1  pixel write request
wr_ready  input  1  framebuffer accepts the write this cycle
wr_x  output  $clog2(WIDTH)  pixel x of the write
wr_y  output  $clog2(HEIGHT)  pixel y of the write
wr_color  output  COLOR_WIDTH  pixel colour of the write
busy  output  1  1 while in DRAW or ERASE

Behaviour:
- Reset: state=IDLE; latched pos=(0,0); latched colour=COLOR_NONE; dx=dy=0; wr_valid=0; wr_x=0; wr_y=0; wr_color=COLOR_NONE; busy=0.
- Registers: latched lx, ly, lcolor, which hold the footprint currently in or being written to the framebuffer. Scan counters dx, dy each span 0..SIZE-1.
- States: IDLE, DRAW, SHOWN, ERASE.
- IDLE: if enable, latch cursor_x, cursor_y, current_color, clear dx/dy, and go to DRAW. Otherwise stay.
- DRAW / ERASE scan the footprint row-major, dx fastest: (lx+0,ly+0), (lx+1,ly+0) ... (lx+SIZE-1,ly+SIZE-1).
  - wr_x = lx+dx, wr_y = ly+dy.
  - wr_color = lcolor in DRAW, COLOR_NONE in ERASE.
  - All write outputs are decoded from registered state and counters, so there is no combinational path from inputs.
- Clipping: form lx+dx and ly+dy one bit wider than the coordinate. The pixel is out of bounds if x >= WIDTH or y >= HEIGHT.
  - Out of bounds: wr_valid=0 and the counter advances in that cycle (1 cycle per skipped pixel).
  - In bounds: wr_valid=1.
- Handshake:
  - An in-bounds pixel holds wr_valid=1 with stable wr_x, wr_y, wr_color until a cycle with wr_ready=1.
  - The counter advances only on valid&&ready.
  - wr_ready is ignored while wr_valid=0.
  - No pixel is ever dropped or written twice within one scan.
- Scan end: the last pixel (dx=dy=SIZE-1) accepted or skipped ends the scan. DRAW goes to SHOWN; ERASE goes to IDLE.
- While busy, cursor_x, cursor_y, current_color and enable are ignored. Changes made during a scan are acted on after the scan completes.
- SHOWN: no writes. Priority, evaluated each cycle:
  - !enable, or (cursor_x,cursor_y) != (lx,ly): go to ERASE at (lx,ly).
  - Otherwise, if current_color != lcolor: latch current_color, clear counters, and go to DRAW at the same position (no erase).
  - Otherwise stay.
- Move latency: SHOWN detects the change, then SIZE*SIZE erase cycles (with wr_ready=1), then 1 IDLE cycle, then DRAW starts.
- Timing: with wr_ready=1 and no clipping, the first write is valid in the cycle after the IDLE cycle that samples enable=1. A full scan takes SIZE*SIZE cycles.
- SIZE=1: single-pixel scan; dx/dy are constant 0.
- Reset mid-scan: the scan is abandoned and wr_valid=0 from the next cycle. Any partial cursor left in the framebuffer is the framebuffer owner's responsibility (cleared at system reset).
- Counters are $clog2(SIZE+1) bits wide, with no wrap beyond SIZE-1.

Test Plan:
1. WIDTH=HEIGHT=8, SIZE=2, wr_ready=1, enable=1, pos (0,0), BLUE after reset -> BLUE writes at (0,0),(1,0),(0,1),(1,1) on 4 consecutive cycles starting 2 cycles after reset deasserts; busy=0 and state SHOWN afterwards.
2. From (1), move cursor to (1,1) -> COLOR_NONE writes at (0,0),(1,0),(0,1),(1,1), then 1 idle cycle, then BLUE writes at (1,1),(2,1),(1,2),(2,2); exactly 8 writes total.
3. Backpressure: wr_ready toggling 0,0,1,0,1,1,... during a draw -> wr_x, wr_y, wr_color stable while wr_valid&&!wr_ready; exactly 4 accepted transfers in order, with none duplicated.
4. Clip: pos (7,7), SIZE=2 -> a single BLUE write at (7,7), 3 cycles with wr_valid=0, SHOWN after 4 cycles. Moving from there erases only (7,7).
5. Colour change to RED at unchanged pos (2,3) -> 4 RED writes covering (2..3,3..4), with no COLOR_NONE writes.
6. enable=0 in SHOWN -> 4 COLOR_NONE writes, then IDLE with no further writes. Reset asserted on the 2nd DRAW cycle -> wr_valid=0 and busy=0 on the next cycle.

Source files
------------

// File: rtl/cursor_sprite_renderer.sv
// cursor_sprite_renderer
//   Paints a SIZE x SIZE square cursor into a shared framebuffer through a
//   valid/ready pixel-write port. It remembers the footprint currently in the
//   framebuffer (lx, ly, lcolor). A move erases that footprint with COLOR_NONE
//   and then draws the new one. A colour-only change redraws in place. Pixels
//   beyond the screen edge are skipped, one cycle per skipped pixel.
//
// Ports
//   clk, reset             system clock; synchronous active-high reset
//   cursor_x, cursor_y     requested cursor top-left corner
//   current_color          requested cursor colour
//   enable                 1 = cursor visible, 0 = cursor hidden
//   wr_valid / wr_ready    pixel-write handshake towards the framebuffer
//   wr_x, wr_y, wr_color   pixel being written
//   busy                   high while a draw or erase scan is running
module cursor_sprite_renderer #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int SIZE        = 2,
  parameter int COLOR_WIDTH = 4,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(WIDTH)-1:0]  cursor_x,
  input  logic [$clog2(HEIGHT)-1:0] cursor_y,
  input  logic [COLOR_WIDTH-1:0]    current_color,
  input  logic                      enable,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [$clog2(WIDTH)-1:0]  wr_x,
  output logic [$clog2(HEIGHT)-1:0] wr_y,
  output logic [COLOR_WIDTH-1:0]    wr_color,
  output logic                      busy
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(SIZE + 1);

  // Screen limits at one bit wider than a coordinate, so that lx+dx and
  // ly+dy can be compared against them without wrapping.
  localparam logic [XW:0]   X_LIM = (XW + 1)'(WIDTH);
  localparam logic [YW:0]   Y_LIM = (YW + 1)'(HEIGHT);
  localparam logic [CW-1:0] LAST  = CW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, DRAW, SHOWN, ERASE} state_t;

  state_t                   state;
  logic [XW-1:0]            lx;
  logic [YW-1:0]            ly;
  logic [COLOR_WIDTH-1:0]   lcolor;
  logic [CW-1:0]            dx;
  logic [CW-1:0]            dy;

  logic [XW:0] px;
  logic [YW:0] py;
  logic        scanning;
  logic        in_bounds;
  logic        step;
  logic        last_px;

  // The write port is decoded purely from registered state and counters, so
  // there is no combinational path from any input to the outputs.
  assign scanning  = (state == DRAW) || (state == ERASE);
  assign px        = {1'b0, lx} + (XW + 1)'(dx);
  assign py        = {1'b0, ly} + (YW + 1)'(dy);
  assign in_bounds = (px < X_LIM) && (py < Y_LIM);

  assign wr_valid  = scanning && in_bounds;
  assign wr_x      = px[XW-1:0];
  assign wr_y      = py[YW-1:0];
  assign wr_color  = (state == DRAW) ? lcolor : COLOR_NONE;
  assign busy      = scanning;

  // A clipped pixel advances without a handshake; an in-bounds pixel waits
  // for wr_ready so it is neither dropped nor repeated.
  assign step      = scanning && (!in_bounds || wr_ready);
  assign last_px   = (dx == LAST) && (dy == LAST);

  // NOTE: state registers use non-blocking assignments so every branch reads
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lx     <= '0;
      ly     <= '0;
      lcolor <= COLOR_NONE;
      dx     <= '0;
      dy     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            lx     <= cursor_x;
            ly     <= cursor_y;
            lcolor <= current_color;
            dx     <= '0;
            dy     <= '0;
            state  <= DRAW;
          end
        end

        DRAW, ERASE: begin
          if (step) begin
            if (last_px) begin
              dx    <= '0;
              dy    <= '0;
              state <= (state == DRAW) ? SHOWN : IDLE;
            end else if (dx == LAST) begin
              dx <= '0;
              dy <= dy + CW'(1);
            end else begin
              dx <= dx + CW'(1);
            end
          end
        end

        SHOWN: begin
          // Hiding or moving must first remove the old footprint; lx/ly are
          // left untouched so the erase scans the old position.
          if (!enable || (cursor_x != lx) || (cursor_y != ly)) begin
            dx    <= '0;
            dy    <= '0;
            state <= ERASE;
          end else if (current_color != lcolor) begin
            lcolor <= current_color;
            dx     <= '0;
            dy     <= '0;
            state  <= DRAW;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_sprite_renderer.sv
// Self-checking bench for cursor_sprite_renderer on an 8x8 screen, SIZE=2.
// A queue-based model lists the pixels each scan must visit; the DUT is
// compared against it every cycle, and directed scenarios pin the model
// with hand-written write sequences.
module tb_cursor_sprite_renderer;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int S    = 2;
  localparam int CWID = 4;

  localparam int NONE  = 0;
  localparam int RED   = 1;
  localparam int GREEN = 2;
  localparam int BLUE  = 3;

  logic            clk = 0;
  logic            reset = 1;
  logic [2:0]      cursor_x = '0;
  logic [2:0]      cursor_y = '0;
  logic [CWID-1:0] current_color = CWID'(BLUE);
  logic            enable = 1;
  logic            wr_valid;
  logic            wr_ready = 1;
  logic [2:0]      wr_x;
  logic [2:0]      wr_y;
  logic [CWID-1:0] wr_color;
  logic            busy;

  cursor_sprite_renderer #(
    .WIDTH(W), .HEIGHT(H), .SIZE(S), .COLOR_WIDTH(CWID)
  ) dut (
    .clk(clk), .reset(reset),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .current_color(current_color), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int x;
    int y;
    int c;
    bit inb;
  } pix_t;

  pix_t pend[$];          // pixels still to be visited by the running scan
  bit   m_live  = 0;
  bit   m_shown = 0;
  bit   m_draw  = 0;
  int   m_lx = 0, m_ly = 0, m_lc = NONE;

  function automatic void load_scan(input bit draw);
    m_draw = draw;
    for (int yy = 0; yy < S; yy++)
      for (int xx = 0; xx < S; xx++) begin
        pix_t p;
        p.x   = m_lx + xx;
        p.y   = m_ly + yy;
        p.c   = draw ? m_lc : NONE;
        p.inb = (p.x < W) && (p.y < H);
        pend.push_back(p);
      end
  endfunction

  // Accepted-write log for directed scenarios, encoded as x<<16|y<<8|colour.
  int log_q[$];
  int log_cyc[$];
  int exp_q[$];
  int ncyc = 0;

  function automatic int enc(input int x, input int y, input int c);
    return (x << 16) | (y << 8) | c;
  endfunction

  bit   prev_hold = 0;
  logic [2:0] prev_x, prev_y;
  logic [CWID-1:0] prev_c;

  // Compare the current cycle, then advance the model using the inputs that
  // the next rising edge will sample (they are stable at the falling edge).
  always @(negedge clk) begin
    if (m_live) begin
      bit exp_valid;
      exp_valid = (pend.size() > 0) && pend[0].inb;
      check("busy", busy, pend.size() > 0);
      check("wr_valid", wr_valid, exp_valid);
      if (exp_valid) begin
        check("wr_x", wr_x, pend[0].x);
        check("wr_y", wr_y, pend[0].y);
        check("wr_color", wr_color, pend[0].c);
      end
      if (prev_hold) begin
        check("hold_valid", wr_valid, 1);
        check("hold_xyc", {wr_x, wr_y, wr_color}, {prev_x, prev_y, prev_c});
      end
    end
    prev_hold = wr_valid && !wr_ready && !reset;
    prev_x = wr_x; prev_y = wr_y; prev_c = wr_color;
    if (!reset && wr_valid && wr_ready) begin
      log_q.push_back(enc(int'(wr_x), int'(wr_y), int'(wr_color)));
      log_cyc.push_back(ncyc);
    end

    if (reset) begin
      pend.delete();
      m_live = 1; m_shown = 0; m_draw = 0;
      m_lx = 0; m_ly = 0; m_lc = NONE;
    end else if (pend.size() > 0) begin
      if (!pend[0].inb || wr_ready) begin
        void'(pend.pop_front());
        if (pend.size() == 0) m_shown = m_draw;
      end
    end else if (m_shown) begin
      if (!enable || int'(cursor_x) != m_lx || int'(cursor_y) != m_ly) begin
        m_shown = 0;
        load_scan(0);
      end else if (int'(current_color) != m_lc) begin
        m_lc = int'(current_color);
        load_scan(1);
      end
    end else if (enable) begin
      m_lx = int'(cursor_x); m_ly = int'(cursor_y); m_lc = int'(current_color);
      load_scan(1);
    end
    ncyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check(name, log_q[i], exp_q[i]);
    log_q.delete(); log_cyc.delete(); exp_q.delete();
  endtask

  task automatic exp_square(input int x, input int y, input int c);
    for (int yy = 0; yy < S; yy++)
      for (int xx = 0; xx < S; xx++)
        exp_q.push_back(enc(x + xx, y + yy, c));
  endtask

  int cyc0;
  int pat[6] = '{0, 0, 1, 0, 1, 1};

  initial begin
    // Reset state
    tick(3);
    check("rst_valid", wr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_x", wr_x, 0);
    check("rst_wr_y", wr_y, 0);
    check("rst_wr_color", wr_color, NONE);

    // 1: draw BLUE at (0,0)
    log_q.delete(); log_cyc.delete();
    reset = 0;
    cyc0 = ncyc;
    tick(8);
    check("t1_first_cycle", log_cyc.size() > 0 ? log_cyc[0] : -1, cyc0 + 1);
    check("t1_last_cycle", log_cyc.size() > 3 ? log_cyc[3] : -1, cyc0 + 4);
    check("t1_busy_after", busy, 0);
    exp_square(0, 0, BLUE);
    check_log("t1_write");

    // 2: move to (1,1): erase, one idle cycle, redraw
    cursor_x = 1; cursor_y = 1;
    tick(20);
    check("t2_idle_gap", log_cyc.size() > 4 ? log_cyc[4] - log_cyc[3] : -1, 2);
    exp_square(0, 0, NONE);
    exp_square(1, 1, BLUE);
    check_log("t2_write");

    // 3: colour change under backpressure
    current_color = CWID'(GREEN);
    for (int i = 0; i < 30; i++) begin
      wr_ready = pat[i % 6][0];
      tick(1);
    end
    wr_ready = 1;
    tick(5);
    exp_square(1, 1, GREEN);
    check_log("t3_write");

    // 4: move to (7,7): only one pixel is on screen
    cursor_x = 7; cursor_y = 7; current_color = CWID'(BLUE);
    tick(20);
    exp_square(1, 1, NONE);
    exp_q.push_back(enc(7, 7, BLUE));
    check_log("t4_clip_draw");
    cursor_x = 2; cursor_y = 3;
    tick(20);
    exp_q.push_back(enc(7, 7, NONE));
    exp_square(2, 3, BLUE);
    check_log("t4_clip_erase");

    // 5: recolour in place, no erase
    current_color = CWID'(RED);
    tick(20);
    exp_square(2, 3, RED);
    check_log("t5_write");

    // 6: hide, then reset on the second DRAW cycle
    enable = 0;
    tick(20);
    exp_square(2, 3, NONE);
    check_log("t6_hide");
    check("t6_busy", busy, 0);
    enable = 1;
    tick(2);
    check("t6_draw_running", busy, 1);
    reset = 1;
    tick(1);
    check("t6_rst_valid", wr_valid, 0);
    check("t6_rst_busy", busy, 0);
    reset = 0;
    tick(10);
    log_q.delete(); log_cyc.delete();

    // Randomised traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      wr_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) cursor_x = 3'($urandom_range(7));
      if ($urandom_range(15) == 0) cursor_y = 3'($urandom_range(7));
      if ($urandom_range(11) == 0) current_color = CWID'($urandom_range(3));
      if ($urandom_range(19) == 0) enable = ~enable;
      reset = ($urandom_range(299) == 0);
      tick(1);
    end
    reset = 0;
    wr_ready = 1;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
